// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter (with sll / sra barrel shifters)
// Brief    : Round-robin share of one 32-bit shift datapath by two requesters.
// Revision : 1.0
// ============================================================================

module sll (
    input  logic [31:0] data_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o
);
    logic [31:0] w_stage [0:5];

    assign w_stage[0] = data_i;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int c_SH = 1 << k;
        assign w_stage[k+1] = shamt_i[k] ? (w_stage[k] << c_SH) : w_stage[k];
    end

    assign result_o = w_stage[5];
endmodule

module sra (
    input  logic [31:0] data_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o
);
    logic [31:0] w_stage [0:5];

    assign w_stage[0] = data_i;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam int c_SH = 1 << k;
        assign w_stage[k+1] = shamt_i[k] ? 32'($signed(w_stage[k]) >>> c_SH) : w_stage[k];
    end

    assign result_o = w_stage[5];
endmodule

module shift_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic        req1_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data
);
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q,    resp_id_d;
    logic [31:0] resp_data_q,  resp_data_d;
    logic        prio_q,       prio_d;

    logic        w_can_accept;
    logic        w_grant;
    logic        w_sel;
    logic [31:0] w_data;
    logic [4:0]  w_shamt;
    logic        w_op;
    logic [31:0] w_sll;
    logic [31:0] w_sra;

    // Readies are forced low while reset is asserted so nothing is consumed.
    assign w_can_accept = !reset && (!resp_valid_q || resp_ready);
    assign req0_ready   = w_can_accept && req0_valid && (!prio_q || !req1_valid);
    assign req1_ready   = w_can_accept && req1_valid && ( prio_q || !req0_valid);
    assign w_grant      = req0_ready || req1_ready;
    assign w_sel        = req1_ready;

    assign w_data  = w_sel ? req1_data  : req0_data;
    assign w_shamt = w_sel ? req1_shamt : req0_shamt;
    assign w_op    = w_sel ? req1_op    : req0_op;

    sll u_sll (.data_i(w_data), .shamt_i(w_shamt), .result_o(w_sll));
    sra u_sra (.data_i(w_data), .shamt_i(w_shamt), .result_o(w_sra));

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        prio_d       = prio_q;
        if (w_grant) begin
            resp_valid_d = 1'b1;
            resp_id_d    = w_sel;
            resp_data_d  = w_op ? w_sra : w_sll;
            prio_d       = ~w_sel;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= 32'h0;
            prio_q       <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            prio_q       <= prio_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Directed vector-table bench for shift_arbiter.
// Revision : 1.0
// ============================================================================

module tb_shift_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    shift_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    typedef struct {
        logic        rst;
        logic        v0;
        logic [31:0] d0;
        logic [4:0]  s0;
        logic        o0;
        logic        v1;
        logic [31:0] d1;
        logic [4:0]  s1;
        logic        o1;
        logic        rr;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_rv;
        logic        e_id;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt [0:22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst;
        req0_valid = v.v0; req0_data = v.d0; req0_shamt = v.s0; req0_op = v.o0;
        req1_valid = v.v1; req1_data = v.d1; req1_shamt = v.s1; req1_op = v.o1;
        resp_ready = v.rr;
    endtask

    function automatic vec_t mk(input logic rst, input logic v0, input logic [31:0] d0,
                                input logic [4:0] s0, input logic o0, input logic v1,
                                input logic [31:0] d1, input logic [4:0] s1, input logic o1,
                                input logic rr, input logic r0, input logic r1,
                                input logic rv, input logic id, input logic [31:0] dat);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.s0 = s0; v.o0 = o0;
        v.v1 = v1; v.d1 = d1; v.s1 = s1; v.o1 = o1; v.rr = rr;
        v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_rv = rv; v.e_id = id; v.e_data = dat;
        return v;
    endfunction

    initial begin
        // Readies are checked against the inputs of the same row; resp_* show
        // the state left by the previous rows.
        //            rst v0 d0            s0  o0 v1 d1            s1  o1 rr  r0 r1 rv id data
        vt[0]  = mk(1, 1, 32'h0000_0001, 4,  0, 1, 32'h8000_0000, 31, 1, 1,  0, 0, 0, 0, 32'h0);
        vt[1]  = mk(1, 1, 32'h0000_0001, 4,  0, 1, 32'h8000_0000, 31, 1, 1,  0, 0, 0, 0, 32'h0);
        vt[2]  = mk(0, 1, 32'h0000_0001, 4,  0, 0, 32'h0,         0,  0, 1,  1, 0, 0, 0, 32'h0);
        vt[3]  = mk(0, 1, 32'h0000_0001, 31, 0, 0, 32'h0,         0,  0, 1,  1, 0, 1, 0, 32'h0000_0010);
        vt[4]  = mk(0, 1, 32'hDEAD_BEEF, 0,  0, 0, 32'h0,         0,  0, 1,  1, 0, 1, 0, 32'h8000_0000);
        vt[5]  = mk(0, 0, 32'h0,         0,  0, 1, 32'h8000_0000, 31, 1, 1,  0, 1, 1, 0, 32'hDEAD_BEEF);
        vt[6]  = mk(0, 0, 32'h0,         0,  0, 1, 32'h7000_0000, 4,  1, 1,  0, 1, 1, 1, 32'hFFFF_FFFF);
        vt[7]  = mk(0, 0, 32'h0,         0,  0, 0, 32'h0,         0,  0, 1,  0, 0, 1, 1, 32'h0700_0000);
        vt[8]  = mk(0, 0, 32'h0,         0,  0, 0, 32'h0,         0,  0, 1,  0, 0, 0, 1, 32'h0700_0000);
        vt[9]  = mk(1, 1, 32'h0000_0003, 1,  0, 1, 32'hF000_0000, 4,  1, 1,  0, 0, 0, 1, 32'h0700_0000);
        vt[10] = mk(0, 1, 32'h0000_0003, 1,  0, 1, 32'hF000_0000, 4,  1, 1,  1, 0, 0, 0, 32'h0);
        vt[11] = mk(0, 1, 32'h0000_0003, 1,  0, 1, 32'hF000_0000, 4,  1, 1,  0, 1, 1, 0, 32'h0000_0006);
        vt[12] = mk(0, 1, 32'h0000_0003, 1,  0, 1, 32'hF000_0000, 4,  1, 1,  1, 0, 1, 1, 32'hFF00_0000);
        vt[13] = mk(0, 1, 32'h0000_0003, 1,  0, 1, 32'hF000_0000, 4,  1, 1,  0, 1, 1, 0, 32'h0000_0006);
        vt[14] = mk(0, 1, 32'h0000_00A5, 8,  0, 1, 32'h8000_0010, 2,  1, 1,  1, 0, 1, 1, 32'hFF00_0000);
        vt[15] = mk(0, 0, 32'h0,         0,  0, 1, 32'h8000_0010, 2,  1, 0,  0, 0, 1, 0, 32'h0000_A500);
        vt[16] = mk(0, 0, 32'h0,         0,  0, 1, 32'h8000_0010, 2,  1, 0,  0, 0, 1, 0, 32'h0000_A500);
        vt[17] = mk(0, 0, 32'h0,         0,  0, 1, 32'h8000_0010, 2,  1, 0,  0, 0, 1, 0, 32'h0000_A500);
        vt[18] = mk(0, 0, 32'h0,         0,  0, 1, 32'h8000_0010, 2,  1, 1,  0, 1, 1, 0, 32'h0000_A500);
        vt[19] = mk(0, 0, 32'h0,         0,  0, 0, 32'h0,         0,  0, 0,  0, 0, 1, 1, 32'hE000_0004);
        vt[20] = mk(1, 1, 32'h0000_0001, 1,  0, 1, 32'h8000_0010, 2,  1, 0,  0, 0, 1, 1, 32'hE000_0004);
        vt[21] = mk(0, 1, 32'h0000_0001, 1,  0, 1, 32'h8000_0010, 2,  1, 0,  1, 0, 0, 0, 32'h0);
        vt[22] = mk(0, 1, 32'h0000_0001, 1,  0, 1, 32'h8000_0010, 2,  1, 0,  0, 0, 1, 0, 32'h0000_0002);

        drive(vt[0]);
        @(posedge clock);

        for (int i = 0; i < 23; i++) begin
            @(negedge clock);
            drive(vt[i]);
            #1;
            chk($sformatf("row%0d req0_ready", i), {31'b0, req0_ready}, {31'b0, vt[i].e_rdy0});
            chk($sformatf("row%0d req1_ready", i), {31'b0, req1_ready}, {31'b0, vt[i].e_rdy1});
            chk($sformatf("row%0d resp_valid", i), {31'b0, resp_valid}, {31'b0, vt[i].e_rv});
            chk($sformatf("row%0d resp_id", i),    {31'b0, resp_id},    {31'b0, vt[i].e_id});
            chk($sformatf("row%0d resp_data", i),  resp_data,           vt[i].e_data);
        end

        // Shift-amount sweep on both operations for requester 0.
        for (int s = 0; s < 64; s++) begin
            logic [31:0] d;
            logic [31:0] exp;
            logic        op;
            d  = (s < 32) ? 32'h9ABC_DEF1 : 32'h3456_789B;
            op = s[0];
            exp = op ? 32'($signed(d) >>> s[4:0]) : (d << s[4:0]);
            @(negedge clock);
            reset = 0; resp_ready = 1; req1_valid = 0;
            req0_valid = 1; req0_data = d; req0_shamt = s[4:0]; req0_op = op;
            #1;
            chk($sformatf("sweep%0d ready", s), {31'b0, req0_ready}, 32'd1);
            @(negedge clock);
            req0_valid = 0;
            #1;
            chk($sformatf("sweep%0d data", s), resp_data, exp);
        end

        // Both requesters valid while consumer toggles: never two grants,
        // never a grant while stalled.
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            req0_valid = 1; req1_valid = 1;
            resp_ready = (c % 3) != 0;
            #1;
            chk($sformatf("mutex%0d", c), {31'b0, req0_ready & req1_ready}, 32'd0);
            if (resp_valid && !resp_ready)
                chk($sformatf("stall%0d", c), {31'b0, req0_ready | req1_ready}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
